// File: rtl/pdm_dac.sv
// PCM-to-PDM output stage: 2-entry sample FIFO feeding a first-order
// error-feedback sigma-delta modulator with a divided PDM bit clock.
`timescale 1ns/1ps
module pdm_dac #(
  parameter int SAMPLE_DEPTH    = 16,
  parameter int OSR             = 32,
  parameter int INPUT_FREQUENCY = 12000000,
  parameter int FREQUENCY       = 400000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SAMPLE_DEPTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    pdm_clk,
  output logic                    pdm_data,
  output logic                    frame_strobe,
  output logic                    underrun
);

  localparam int DIV_COUNT = INPUT_FREQUENCY / (2 * FREQUENCY) - 1;
  localparam int HALF      = DIV_COUNT / 2;
  localparam int DW        = (DIV_COUNT > 1) ? $clog2(DIV_COUNT + 1) : 1;
  localparam int BW        = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_COUNT);
  localparam logic [DW-1:0] DIV_MID = DW'(HALF);
  localparam logic [SAMPLE_DEPTH-1:0] SIGN =
    {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};

  logic [DW-1:0]           div;
  logic [DW-1:0]           div_nxt;
  logic [BW-1:0]           bit_count;
  logic [SAMPLE_DEPTH-1:0] mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic [SAMPLE_DEPTH-1:0] cur;
  logic [SAMPLE_DEPTH-1:0] acc;
  logic [SAMPLE_DEPTH-1:0] sel;
  logic [SAMPLE_DEPTH-1:0] u;
  logic [SAMPLE_DEPTH:0]   acc_nxt;
  logic                    armed;
  logic                    bit_tick;
  logic                    boundary;
  logic                    push;
  logic                    pop;

  assign div_nxt  = (div == '0) ? DIV_MAX : div - 1'b1;
  assign bit_tick = enable && (div == DIV_MID);
  assign boundary = bit_tick && (bit_count == '0);

  assign sample_ready = armed && enable && (count != 2'd2);
  assign push = sample_valid && sample_ready;
  assign pop  = boundary && (count != 2'd0);

  assign frame_strobe = boundary;
  assign underrun     = boundary && (count == 2'd0);

  // The tick that pops a new sample also modulates it.
  assign sel     = pop ? mem[rd_ptr] : cur;
  assign u       = sel ^ SIGN;
  assign acc_nxt = {1'b0, acc} + {1'b0, u};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      div       <= DIV_MAX;
      pdm_clk   <= 1'b0;
      pdm_data  <= 1'b0;
      bit_count <= '0;
      acc       <= '0;
      cur       <= '0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (!enable) begin
        div       <= DIV_MAX;
        pdm_clk   <= 1'b0;
        pdm_data  <= 1'b0;
        bit_count <= '0;
        acc       <= '0;
        cur       <= '0;
        count     <= 2'd0;
        wr_ptr    <= 1'b0;
        rd_ptr    <= 1'b0;
      end else begin
        div     <= div_nxt;
        pdm_clk <= (div_nxt > DIV_MID);
        if (bit_tick) begin
          pdm_data  <= acc_nxt[SAMPLE_DEPTH];
          acc       <= acc_nxt[SAMPLE_DEPTH-1:0];
          bit_count <= bit_count + 1'b1;
        end
        if (pop) begin
          cur    <= mem[rd_ptr];
          rd_ptr <= ~rd_ptr;
        end
        if (push) wr_ptr <= ~wr_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_pdm_dac.sv
// Bench for pdm_dac: random and directed PCM traffic checked every cycle
// against a cycle-count/queue reference model of the PDM output stage.
`timescale 1ns/1ps
module tb_pdm_dac;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        pdm_clk;
  logic        pdm_data;
  logic        frame_strobe;
  logic        underrun;

  pdm_dac dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pdm_clk      (pdm_clk),
    .pdm_data     (pdm_data),
    .frame_strobe (frame_strobe),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int src[$];
  int q[$];
  int c, ticks, cur, acc;
  bit data, clkv, armed;
  int ones, nticks, ncyc, last_strobe;

  task automatic chk(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b at t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    c = 0;
    ticks = 0;
    q.delete();
    cur = 0;
    acc = 0;
    data = 1'b0;
    clkv = 1'b0;
    last_strobe = -1;
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic cyc();
    bit rdy, tick, bnd, und, push;
    int s;
    sample_valid = (src.size() > 0);
    sample_in = sample_valid ? 16'(src[0]) : 16'($urandom);
    @(negedge clk);
    rdy  = enable && armed && (q.size() < 2);
    tick = enable && (c % 15 == 7);
    bnd  = tick && (ticks % 32 == 0);
    und  = bnd && (q.size() == 0);
    chk("pdm_clk", pdm_clk, clkv);
    chk("pdm_data", pdm_data, data);
    chk("sample_ready", sample_ready, rdy);
    chk("frame_strobe", frame_strobe, bnd);
    chk("underrun", underrun, und);
    push = sample_valid && rdy;
    if (bnd) begin
      if (last_strobe >= 0)
        chk_int("strobe_gap", ncyc - last_strobe, 480);
      last_strobe = ncyc;
    end
    @(posedge clk);
    armed = 1'b1;
    if (!enable) begin
      model_reset();
    end else begin
      if (bnd && q.size() > 0) cur = q.pop_front();
      if (tick) begin
        s = acc + cur + 32768;
        data = (s >= 65536);
        acc = s % 65536;
        ticks++;
        nticks++;
        ones += int'(data);
      end
      if (push) q.push_back(src.pop_front());
      c++;
      clkv = (14 - (c % 15)) > 7;
    end
    ncyc++;
    #1;
  endtask

  task automatic run(int n, bit rnd);
    logic signed [15:0] r;
    for (int i = 0; i < n; i++) begin
      if (rnd && src.size() < 2 && $urandom_range(3) == 0) begin
        r = 16'($urandom);
        src.push_back(int'(r));
      end
      cyc();
    end
  endtask

  // Restart from a clean disable, load one sample, count a frame's ones.
  task automatic frame_ones(int smp, int exp_ones, string tag);
    int budget;
    enable = 1'b0;
    src.delete();
    run(3, 1'b0);
    enable = 1'b1;
    src.push_back(smp);
    src.push_back(smp);
    ones = 0;
    nticks = 0;
    budget = 0;
    while (nticks < 32 && budget < 1000) begin
      cyc();
      budget++;
    end
    chk_int({tag, "_timeout"}, int'(nticks == 32), 1);
    chk_int(tag, ones, exp_ones);
  endtask

  task automatic reset_check();
    rst = 1'b1;
    #1;
    chk("rst_pdm_clk", pdm_clk, 1'b0);
    chk("rst_pdm_data", pdm_data, 1'b0);
    chk("rst_ready", sample_ready, 1'b0);
    chk("rst_strobe", frame_strobe, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    armed = 1'b0;
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    enable = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    model_reset();
    armed = 1'b0;
    ncyc = 0;
    ones = 0;
    nticks = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_check();
    enable = 1'b1;
    run(2, 1'b0);

    // Zero input: alternating bits.
    for (int i = 0; i < 4; i++) src.push_back(0);
    run(4 * 480, 1'b0);

    // Random traffic with random valid gaps.
    run(6 * 480, 1'b1);

    // Density extremes and a mid-scale value from acc=0.
    frame_ones(16384, 24, "ones_16384");
    frame_ones(-32768, 0, "ones_min");
    frame_ones(32767, 31, "ones_max");

    // Underrun: one sample then starve.
    enable = 1'b0;
    src.delete();
    run(3, 1'b0);
    enable = 1'b1;
    src.push_back(8192);
    run(3 * 480, 1'b0);

    // Backpressure: three samples offered back to back.
    src.push_back(1000);
    src.push_back(-20000);
    src.push_back(30000);
    run(3 * 480, 1'b0);

    // Enable drop at bit 10 of a frame.
    budget = 0;
    while (ticks % 32 != 10 && budget < 600) begin
      cyc();
      budget++;
    end
    chk_int("drop_timeout", int'(ticks % 32 == 10), 1);
    enable = 1'b0;
    src.delete();
    run(5, 1'b0);
    enable = 1'b1;
    run(2 * 480, 1'b0);

    // Reset mid-stream, then resume.
    run(300, 1'b1);
    reset_check();
    run(2 * 480, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
